lock_access_controller: RTL and testbench
=========================================

Name: lock_access_controller

Overview:
Sequencer for serial code entry. It collects CODE_LEN bits from the key input and compares them against a stored code. It drives the unlock output and enforces a failed-attempt lockout with an alarm. While the lock is open, the stored code can be reprogrammed. It sits between the debounced key/button logic and the lock actuator and LED display.

Parameters:
CODE_LEN, 4, number of bits per code entry (2..8)
DEFAULT_CODE, 4'b1010, code register value after reset; width CODE_LEN
MAX_FAILS, 3, consecutive failed checks that trigger lockout (1..7)
UNLOCK_CYCLES, 8, sys_clk cycles the lock stays open (>=1)
LOCKOUT_CYCLES, 16, sys_clk cycles of lockout/alarm (>=1)

Ports:
sys_clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
bit_valid  input  1  single-cycle strobe; bit_in is sampled when high
bit_in  input  1  entered code bit
abort  input  1  discard the partial entry; return to IDLE
prog_en  input  1  request code reprogramming; honoured only in OPEN
unlocked  output  1  high while state==OPEN
alarm  output  1  high while state==LOCKOUT
fail_cnt  output  3  current consecutive-failure count
state  output  3  encoded FSM state, for LEDs/debug

Behaviour:
- All state is in registers clocked on the sys_clk rising edge. reset clears asynchronously to:
  - state=IDLE, entry shift register=0, bit counter=0, timer=0, fail_cnt=0
  - code_reg=DEFAULT_CODE
  - unlocked=0, alarm=0
- unlocked, alarm and state are decoded directly from the state register, with no extra register stage.
- State encoding: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, LOCKOUT=4, PROGRAM=5. Codes 6 and 7 go to IDLE on the next edge.
- Bit shifting (ENTRY and PROGRAM): the shift register updates as sr<={sr[CODE_LEN-2:0],bit_in}, so the first bit entered ends up as the MSB. Each accepted bit increments the bit counter.
- IDLE:
  - bit_valid: shift the bit in, counter=1, go to ENTRY.
  - abort is a no-op.
- ENTRY:
  - bit_valid: shift the bit in and increment the counter.
  - When the accepted bit makes the counter equal CODE_LEN: go to CHECK and clear the counter.
  - abort (has priority over bit_valid in the same cycle): clear the shift register and counter, go to IDLE, fail_cnt unchanged.
- CHECK lasts exactly one cycle; bit_valid is ignored.
  - Match (sr==code_reg): fail_cnt=0, timer=UNLOCK_CYCLES-1, go to OPEN.
  - Mismatch with fail_cnt+1==MAX_FAILS: fail_cnt increments, timer=LOCKOUT_CYCLES-1, go to LOCKOUT.
  - Mismatch otherwise: fail_cnt increments, go to IDLE.
- Timing: if the last bit is sampled at edge E, state==CHECK after E and state==OPEN (or LOCKOUT/IDLE) after E+1.
- OPEN: unlocked=1, and the timer decrements every cycle.
  - prog_en: clear the counter, go to PROGRAM. prog_en has priority over timer expiry.
  - Timer==0 and no prog_en: go to IDLE.
  - Without prog_en, unlocked stays high for exactly UNLOCK_CYCLES cycles.
  - bit_valid is ignored.
- PROGRAM: unlocked=0.
  - Accept CODE_LEN bits through the same shift path.
  - On the CODE_LEN-th bit: load code_reg with the completed value (including that bit) and go to IDLE.
  - abort: go to IDLE with code_reg unchanged.
- LOCKOUT: alarm=1.
  - bit_valid, abort and prog_en are all ignored.
  - The timer decrements; at 0, fail_cnt=0 and go to IDLE.
  - alarm stays high for exactly LOCKOUT_CYCLES cycles.
- A successful CHECK is the only event that clears fail_cnt, apart from lockout expiry and reset.
- fail_cnt saturates at MAX_FAILS and never wraps.
- Reset asserted mid-entry, mid-OPEN or mid-LOCKOUT discards everything. code_reg returns to DEFAULT_CODE.

Test Plan:
- Reset, then bits 1,0,1,0 on consecutive cycles → CHECK one cycle after the 4th bit, then unlocked=1 for exactly 8 cycles, then IDLE; fail_cnt=0 throughout.
- Bits 1,1,1,1 three times, with idle gaps between entries → fail_cnt 1,2 after the first two entries. The third entry → LOCKOUT, alarm=1 for 16 cycles; bits entered during lockout are ignored; then IDLE with fail_cnt=0.
- Bits 1,0 then abort asserted together with bit_valid → IDLE, fail_cnt unchanged. A following full 1,0,1,0 entry unlocks.
- Unlock, assert prog_en in the 3rd OPEN cycle, enter 0,1,1,0 → IDLE. Entry 1,0,1,0 now fails (fail_cnt=1); entry 0,1,1,0 unlocks.
- Assert reset asynchronously (between clock edges) during LOCKOUT and during PROGRAM → outputs go to 0 immediately, state=IDLE, and code 1,0,1,0 unlocks again.
- Two mismatches then one correct entry → fail_cnt returns to 0. Two further mismatches do not trigger lockout (fail_cnt=2).

Source files
------------

// File: rtl/lock_access_controller.sv
// lock_access_controller
//   Serial code-entry sequencer. Collects CODE_LEN bits (first bit ends up as
//   MSB), compares against a programmable code register, opens the lock for
//   UNLOCK_CYCLES cycles on a match, and enforces a LOCKOUT_CYCLES alarm after
//   MAX_FAILS consecutive mismatches. While open, the code can be reprogrammed.
//
// Ports
//   sys_clk   in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   bit_valid in   single-cycle strobe qualifying bit_in
//   bit_in    in   entered code bit
//   abort     in   drop a partial entry / programming sequence
//   prog_en   in   request reprogramming (only honoured while open)
//   unlocked  out  high while in OPEN
//   alarm     out  high while in LOCKOUT
//   fail_cnt  out  consecutive failed-check count
//   state     out  encoded FSM state
module lock_access_controller #(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b1010,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  UNLOCK_CYCLES  = 8,
  parameter int                  LOCKOUT_CYCLES = 16
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       abort,
  input  logic       prog_en,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] fail_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4,
    S_PROGRAM = 3'd5
  } state_t;

  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(CODE_LEN + 1);

  localparam logic [TW-1:0] UNLOCK_LD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [CW-1:0] LAST_BIT   = CW'(CODE_LEN - 1);
  localparam logic [2:0]    MAX_F      = 3'(MAX_FAILS);

  state_t              state_q;
  logic [CODE_LEN-1:0] sr_q;
  logic [CODE_LEN-1:0] code_reg;
  logic [CW-1:0]       cnt_q;
  logic [TW-1:0]       timer_q;
  logic [2:0]          fail_q;

  // Shift path shared by ENTRY and PROGRAM; first bit entered lands in the MSB.
  logic [CODE_LEN-1:0] sr_next;
  assign sr_next = {sr_q[CODE_LEN-2:0], bit_in};

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      code_reg <= DEFAULT_CODE;
      cnt_q    <= '0;
      timer_q  <= '0;
      fail_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bit_valid) begin
            sr_q    <= sr_next;
            cnt_q   <= CW'(1);
            state_q <= S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (abort) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (bit_valid) begin
            sr_q <= sr_next;
            if (cnt_q == LAST_BIT) begin
              cnt_q   <= '0;
              state_q <= S_CHECK;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        S_CHECK: begin
          if (sr_q == code_reg) begin
            fail_q  <= '0;
            timer_q <= UNLOCK_LD;
            state_q <= S_OPEN;
          end else begin
            // Saturate rather than wrap; in practice lockout is reached first.
            if (fail_q < MAX_F) fail_q <= fail_q + 3'd1;
            if (fail_q + 3'd1 >= MAX_F) begin
              timer_q <= LOCKOUT_LD;
              state_q <= S_LOCKOUT;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        S_OPEN: begin
          // Reprogramming request wins over timer expiry.
          if (prog_en) begin
            cnt_q   <= '0;
            state_q <= S_PROGRAM;
          end else if (timer_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end

        S_PROGRAM: begin
          if (abort) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (bit_valid) begin
            sr_q <= sr_next;
            if (cnt_q == LAST_BIT) begin
              code_reg <= sr_next;
              cnt_q    <= '0;
              state_q  <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        S_LOCKOUT: begin
          if (timer_q == '0) begin
            fail_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign unlocked = (state_q == S_OPEN);
  assign alarm    = (state_q == S_LOCKOUT);
  assign fail_cnt = fail_q;
  assign state    = state_q;

endmodule

// File: tb/tb_lock_access_controller.sv
// Directed bench for lock_access_controller: inputs driven on the falling
// edge, outputs sampled on the falling edge (or mid-cycle around async reset).
module tb_lock_access_controller;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       bit_valid;
  logic       bit_in;
  logic       abort;
  logic       prog_en;
  logic       unlocked;
  logic       alarm;
  logic [2:0] fail_cnt;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int n;

  localparam int IDLE = 0, ENTRY = 1, CHECK = 2, OPEN = 3, LOCKOUT = 4, PROGRAM = 5;

  lock_access_controller dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .bit_valid(bit_valid),
    .bit_in   (bit_in),
    .abort    (abort),
    .prog_en  (prog_en),
    .unlocked (unlocked),
    .alarm    (alarm),
    .fail_cnt (fail_cnt),
    .state    (state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Four bits on consecutive cycles, MSB first. Returns at the falling edge
  // right after the edge that sampled the last bit.
  task automatic send_code(input logic [3:0] c);
    for (int i = 3; i >= 0; i--) begin
      @(negedge sys_clk);
      bit_valid = 1'b1;
      bit_in    = c[i];
    end
    @(negedge sys_clk);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  // Counts falling edges for which unlocked stays high (bounded).
  task automatic count_open(output int cnt);
    cnt = 0;
    while (unlocked && cnt < 100) begin
      cnt++;
      @(negedge sys_clk);
    end
  endtask

  task automatic gap(input int cycles);
    repeat (cycles) @(negedge sys_clk);
  endtask

  // Full failing entry that is not expected to trigger lockout.
  task automatic bad_entry(input string tag, input logic [3:0] c, input int exp_fail);
    send_code(c);
    chk({tag, "_chk"}, state, CHECK);
    @(negedge sys_clk);
    chk({tag, "_st"}, state, IDLE);
    chk({tag, "_fc"}, fail_cnt, exp_fail);
    gap(2);
  endtask

  // Correct entry that opens for the full window.
  task automatic good_entry(input string tag, input logic [3:0] c);
    int k;
    send_code(c);
    chk({tag, "_chk"}, state, CHECK);
    @(negedge sys_clk);
    chk({tag, "_open"}, state, OPEN);
    chk({tag, "_fc"}, fail_cnt, 0);
    count_open(k);
    chk({tag, "_len"}, k, 8);
    chk({tag, "_idle"}, state, IDLE);
  endtask

  initial begin
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; abort = 1'b0; prog_en = 1'b0;
    gap(2);
    chk("rst_state", state, IDLE);
    chk("rst_unl", unlocked, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_fc", fail_cnt, 0);
    reset = 1'b0;
    gap(1);

    // 1: default code opens for exactly 8 cycles
    good_entry("t1", 4'b1010);
    gap(2);

    // 2: three wrong entries -> lockout, inputs ignored, counter cleared after
    bad_entry("t2a", 4'b1111, 1);
    bad_entry("t2b", 4'b1111, 2);
    send_code(4'b1111);
    chk("t2c_chk", state, CHECK);
    @(negedge sys_clk);
    chk("t2_lock", state, LOCKOUT);
    chk("t2_alarm", alarm, 1);
    chk("t2_fc", fail_cnt, 3);
    n = 0;
    while (alarm && n < 100) begin
      n++;
      bit_valid = (n <= 6);
      bit_in    = n[0];
      abort     = (n == 7);
      prog_en   = (n == 8);
      @(negedge sys_clk);
    end
    bit_valid = 1'b0; abort = 1'b0; prog_en = 1'b0;
    chk("t2_alarm_len", n, 16);
    chk("t2_after_st", state, IDLE);
    chk("t2_after_fc", fail_cnt, 0);
    gap(2);

    // 3: abort mid-entry (together with a bit) keeps fail_cnt
    bad_entry("t3pre", 4'b1111, 1);
    @(negedge sys_clk); bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge sys_clk); bit_in = 1'b0;
    @(negedge sys_clk); chk("t3_entry", state, ENTRY);
    bit_in = 1'b1; abort = 1'b1;
    @(negedge sys_clk); bit_valid = 1'b0; abort = 1'b0;
    chk("t3_abort_st", state, IDLE);
    chk("t3_abort_fc", fail_cnt, 1);
    gap(2);
    good_entry("t3", 4'b1010);
    gap(2);

    // 4: reprogram to 0110 from the 3rd open cycle
    send_code(4'b1010);
    @(negedge sys_clk); chk("t4_open1", state, OPEN);
    @(negedge sys_clk);
    @(negedge sys_clk); chk("t4_open3", unlocked, 1);
    prog_en = 1'b1;
    @(negedge sys_clk); prog_en = 1'b0;
    chk("t4_prog", state, PROGRAM);
    chk("t4_prog_unl", unlocked, 0);
    send_code(4'b0110);
    chk("t4_prog_done", state, IDLE);
    gap(2);
    bad_entry("t4old", 4'b1010, 1);
    good_entry("t4new", 4'b0110);
    gap(2);

    // 5a: async reset during lockout
    bad_entry("t5a", 4'b1111, 1);
    bad_entry("t5b", 4'b1111, 2);
    send_code(4'b1111);
    @(negedge sys_clk); chk("t5_lock", alarm, 1);
    gap(3);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_alarm", alarm, 0);
    chk("t5_rst_st", state, IDLE);
    chk("t5_rst_fc", fail_cnt, 0);
    #1 reset = 1'b0;
    gap(2);
    good_entry("t5c", 4'b1010);  // default code restored
    gap(2);

    // 5b: async reset mid-programming
    send_code(4'b1010);
    @(negedge sys_clk); prog_en = 1'b1;
    @(negedge sys_clk); prog_en = 1'b0;
    chk("t5_prog", state, PROGRAM);
    bit_valid = 1'b1; bit_in = 1'b0;
    @(negedge sys_clk); bit_in = 1'b1;
    @(negedge sys_clk); bit_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t5_prst_st", state, IDLE);
    chk("t5_prst_unl", unlocked, 0);
    #1 reset = 1'b0;
    gap(2);
    good_entry("t5d", 4'b1010);
    gap(2);

    // 6: success clears fail count; two later misses stay below lockout
    bad_entry("t6a", 4'b0000, 1);
    bad_entry("t6b", 4'b0001, 2);
    good_entry("t6c", 4'b1010);
    gap(2);
    bad_entry("t6d", 4'b1110, 1);
    bad_entry("t6e", 4'b0101, 2);
    chk("t6_no_alarm", alarm, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
